// File: rtl/sd_block_responder.sv
// Responder side of the sd_lba/sd_rd/sd_wr/sd_ack sector protocol: moves 512-byte sectors
// for two drive images between the requester's byte buffer and a byte-wide backing memory.
module sd_block_responder #(
  parameter int          ADDR_W    = 24,
  parameter logic [31:0] DRV1_BASE = 32'h0010_0000,
  parameter logic [31:0] MAX_LBA   = 32'd1439
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic [1:0]        sd_rd,
  input  logic [1:0]        sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic              lba_err,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ACK     = 4'd1,
    S_RD_MEM  = 4'd2,
    S_RD_STB  = 4'd3,
    S_WR_ADDR = 4'd4,
    S_WR_LAT  = 4'd5,
    S_WR_MEM  = 4'd6,
    S_WR_NEXT = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t      state, state_n;
  logic        ack_q;
  logic        drive_q;
  logic        write_q;
  logic [31:0] lba_q;
  logic        err_q;
  logic [8:0]  idx;
  logic [7:0]  data_q;

  logic        req_any;
  logic        req_drive;
  logic        req_write;
  logic        last_byte;

  // Memory handshake: mem_rd/mem_wr is a level held with a stable address (and mem_din)
  // until mem_ready pulses for one cycle; mem_ready outside RD_MEM/WR_MEM is ignored.
  always_comb begin
    req_any   = |{sd_rd, sd_wr};
    req_drive = 1'b0;
    req_write = 1'b0;
    if (sd_rd[0]) begin
      req_drive = 1'b0;
      req_write = 1'b0;
    end else if (sd_wr[0]) begin
      req_drive = 1'b0;
      req_write = 1'b1;
    end else if (sd_rd[1]) begin
      req_drive = 1'b1;
      req_write = 1'b0;
    end else if (sd_wr[1]) begin
      req_drive = 1'b1;
      req_write = 1'b1;
    end
  end

  assign last_byte = (idx == 9'd511);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (req_any) state_n = S_ACK;
      S_ACK:     state_n = write_q ? S_WR_ADDR : S_RD_MEM;
      S_RD_MEM:  if (err_q || mem_ready) state_n = S_RD_STB;
      S_RD_STB:  state_n = last_byte ? S_DONE : S_RD_MEM;
      S_WR_ADDR: state_n = S_WR_LAT;
      S_WR_LAT:  state_n = err_q ? S_WR_NEXT : S_WR_MEM;
      S_WR_MEM:  if (mem_ready) state_n = S_WR_NEXT;
      S_WR_NEXT: state_n = last_byte ? S_DONE : S_WR_ADDR;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= S_IDLE;
      ack_q   <= 1'b0;
      drive_q <= 1'b0;
      write_q <= 1'b0;
      lba_q   <= 32'd0;
      err_q   <= 1'b0;
      idx     <= 9'd0;
      data_q  <= 8'd0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            drive_q <= req_drive;
            write_q <= req_write;
            lba_q   <= sd_lba;
            err_q   <= (sd_lba > MAX_LBA);
            idx     <= 9'd0;
          end
        end
        S_ACK:    ack_q <= 1'b1;
        // Out-of-range sectors read back as zeros without touching memory.
        S_RD_MEM: begin
          if (err_q) data_q <= 8'h00;
          else if (mem_ready) data_q <= mem_dout;
        end
        S_RD_STB, S_WR_NEXT: if (!last_byte) idx <= idx + 9'd1;
        S_WR_LAT: data_q <= sd_buff_din;
        S_DONE:   ack_q <= 1'b0;
        default:  ;
      endcase
    end
  end

  assign sd_ack       = ack_q;
  assign sd_buff_addr = idx;
  assign sd_buff_dout = data_q;
  assign sd_buff_wr   = (state == S_RD_STB);
  assign mem_rd       = (state == S_RD_MEM) && !err_q;
  assign mem_wr       = (state == S_WR_MEM);
  assign mem_din      = data_q;
  assign mem_addr     = ADDR_W'(drive_q ? DRV1_BASE : 32'd0) + ADDR_W'({lba_q, 9'd0}) + ADDR_W'(idx);
  assign lba_err      = err_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_sd_block_responder.sv
// Bench for sd_block_responder: requester and backing-memory models, sector-level expectation
// queues, and directed transfers covering reset, both directions, arbitration and bad LBAs.
module tb_sd_block_responder;

  localparam int          ADDR_W  = 24;
  localparam logic [31:0] MAX_LBA = 32'd1439;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       sd_lba = 32'd0;
  logic [1:0]        sd_rd = 2'b00;
  logic [1:0]        sd_wr = 2'b00;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din = 8'h00;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout = 8'h00;
  logic              mem_ready = 1'b0;
  logic              lba_err;
  logic [3:0]        dbg_state;

  sd_block_responder dut (
    .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_ready(mem_ready), .lba_err(lba_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc = cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [16:0] exp_stb_q[$];   // {buff addr, read data}
  logic [32:0] exp_mem_q[$];   // {is_write, mem addr, write data}
  logic [1:0]  served_log[$];  // {drive, is_write}
  logic [7:0]  wmem [logic [23:0]];
  int first_stb_cyc = -1;
  int accept_cyc = 0;
  int ack_hi_cnt = 0;
  int n_mem_wr = 0;
  int mem_delay_max = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unwritten memory reads back as the low byte of its address.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (wmem.exists(a)) return wmem[a];
    return a[7:0];
  endfunction

  // Sector-level model: what one whole transfer must show on the buffer and memory ports.
  function automatic void expect_xfer(input logic drv, input logic dw, input logic [31:0] lba);
    logic [63:0] full;
    logic [23:0] a;
    logic [8:0]  i9;
    logic        err;
    err = (lba > MAX_LBA);
    for (int i = 0; i < 512; i++) begin
      full = (drv ? 64'h10_0000 : 64'd0) + {32'd0, lba} * 64'd512 + 64'(i);
      a    = full[23:0];
      i9   = 9'(i);
      if (!dw) begin
        exp_stb_q.push_back({i9, err ? 8'h00 : mem_byte(a)});
        if (!err) exp_mem_q.push_back({1'b0, a, 8'h00});
      end else if (!err) begin
        exp_mem_q.push_back({1'b1, a, ~i9[7:0]});
      end
    end
  endfunction

  // ---------------- requester write-data and memory models ----------------
  logic [8:0] prev_addr = 9'd0;
  logic       mem_busy = 1'b0;
  int         mem_cnt = 0;

  always begin
    @(posedge clk_sys);
    #2;
    sd_buff_din = ~prev_addr[7:0];
    prev_addr   = sd_buff_addr;
    if (reset) begin
      mem_busy  = 1'b0;
      mem_ready = 1'b0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      mem_busy  = 1'b0;
      mem_dout  = 8'($urandom);
    end else if (mem_busy) begin
      if (mem_cnt == 0) begin
        mem_ready = 1'b1;
        if (mem_wr) begin
          wmem[mem_addr] = mem_din;
          n_mem_wr++;
        end else begin
          mem_dout = mem_byte(mem_addr);
        end
      end else begin
        mem_cnt--;
      end
    end else if (mem_rd || mem_wr) begin
      mem_busy = 1'b1;
      mem_cnt  = (mem_delay_max == 0) ? 0 : int'($urandom_range(mem_delay_max, 0));
    end
  end

  // ---------------- compare process ----------------
  logic [16:0] e_stb;
  logic [32:0] e_mem;
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (sd_ack) ack_hi_cnt++;
      if (sd_ack || mem_rd || mem_wr || sd_buff_wr)
        check("bus_rules", {62'd0, mem_rd & mem_wr, (mem_rd | mem_wr | sd_buff_wr) & ~sd_ack}, 64'd0);
      if ((mem_rd || mem_wr) && exp_mem_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL mem_req: got request rd=%0b wr=%0b addr=%0h, want none", mem_rd, mem_wr, mem_addr);
      end
      if (sd_buff_wr) begin
        if (first_stb_cyc < 0) first_stb_cyc = cyc;
        if (exp_stb_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL strobe: got extra strobe addr=%0d, want none", sd_buff_addr);
        end else begin
          e_stb = exp_stb_q.pop_front();
          check("strobe_addr_data", {47'd0, sd_buff_addr, sd_buff_dout}, {47'd0, e_stb});
        end
      end
      if (mem_ready && (mem_rd || mem_wr) && exp_mem_q.size() != 0) begin
        e_mem = exp_mem_q.pop_front();
        check("mem_dir", {63'd0, mem_wr}, {63'd0, e_mem[32]});
        check("mem_addr", {40'd0, mem_addr}, {40'd0, e_mem[31:8]});
        if (e_mem[32]) check("mem_din", {56'd0, mem_din}, {56'd0, e_mem[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (sd_ack !== lvl && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, {63'd0, sd_ack}, {63'd0, lvl});
  endtask

  // Holds the given requests like the disk controller: each one drops once its ack is seen.
  task automatic serve(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] lba);
    logic [1:0] hr, hw;
    logic       drv, dw;
    hr = rd;
    hw = wr;
    @(negedge clk_sys);
    sd_lba = lba;
    sd_rd  = hr;
    sd_wr  = hw;
    first_stb_cyc = -1;
    accept_cyc    = cyc + 1;
    ack_hi_cnt    = 0;
    while ((hr | hw) != 2'b00) begin
      if (hr[0])      {drv, dw} = 2'b00;
      else if (hw[0]) {drv, dw} = 2'b01;
      else if (hr[1]) {drv, dw} = 2'b10;
      else            {drv, dw} = 2'b11;
      served_log.push_back({drv, dw});
      expect_xfer(drv, dw, lba);
      wait_ack(1'b1, 10, "ack_rise");
      if (dw) hw[drv] = 1'b0;
      else    hr[drv] = 1'b0;
      sd_rd = hr;
      sd_wr = hw;
      wait_ack(1'b0, 8000, "ack_fall");
      check("lba_err", {63'd0, lba_err}, {63'd0, lba > MAX_LBA});
      check("stb_left", 64'(exp_stb_q.size()), 64'd0);
      check("mem_left", 64'(exp_mem_q.size()), 64'd0);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_ack", {63'd0, sd_ack}, 64'd0);
    check("rst_buff", {46'd0, sd_buff_addr, sd_buff_dout, sd_buff_wr}, 64'd0);
    check("rst_mem", {30'd0, mem_addr, mem_rd, mem_wr, mem_din}, 64'd0);
    check("rst_err_state", {59'd0, lba_err, dbg_state}, 64'd0);
    @(posedge clk_sys); #1 reset = 1'b0;

    // 1: reset in the middle of a read, then a fresh read starts from byte 0
    @(negedge clk_sys);
    sd_lba = 32'd0;
    expect_xfer(1'b0, 1'b0, 32'd0);
    sd_rd = 2'b01;
    wait_ack(1'b1, 10, "t1_ack_rise");
    sd_rd = 2'b00;
    n = 0;
    while (!(sd_buff_wr === 1'b1 && sd_buff_addr === 9'd100) && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check("t1_reach_idx100", {55'd0, sd_buff_addr}, 64'd100);
    @(posedge clk_sys); #1 reset = 1'b1;
    @(posedge clk_sys); #1;
    exp_stb_q.delete();
    exp_mem_q.delete();
    @(negedge clk_sys);
    check("t1_ack_low", {63'd0, sd_ack}, 64'd0);
    check("t1_mem_rd_low", {63'd0, mem_rd}, 64'd0);
    check("t1_strobe_low", {63'd0, sd_buff_wr}, 64'd0);
    check("t1_state_idle", {60'd0, dbg_state}, 64'd0);
    @(posedge clk_sys); #1 reset = 1'b0;
    serve(2'b01, 2'b00, 32'd0);

    // 2: drive 0 read of LBA 3; pin the model, then latency and ack length
    expect_xfer(1'b0, 1'b0, 32'd3);
    check("t2_model_first", {47'd0, exp_stb_q[0]}, {47'd0, 9'd0, 8'h00});
    check("t2_model_last", {47'd0, exp_stb_q[511]}, {47'd0, 9'd511, 8'hFF});
    check("t2_model_mem0", {31'd0, exp_mem_q[0]}, {31'd0, 1'b0, 24'h000600, 8'h00});
    check("t2_model_mem511", {31'd0, exp_mem_q[511]}, {31'd0, 1'b0, 24'h0007FF, 8'h00});
    exp_stb_q.delete();
    exp_mem_q.delete();
    serve(2'b01, 2'b00, 32'd3);
    check("t2_latency", 64'(first_stb_cyc - accept_cyc), 64'd3);
    check("t2_ack_cycles", 64'(ack_hi_cnt), 64'd1537);

    // 3: drive 1 write of LBA 0 with data ~addr
    expect_xfer(1'b1, 1'b1, 32'd0);
    check("t3_model_mem0", {31'd0, exp_mem_q[0]}, {31'd0, 1'b1, 24'h100000, 8'hFF});
    check("t3_model_mem511", {31'd0, exp_mem_q[511]}, {31'd0, 1'b1, 24'h1001FF, 8'h00});
    exp_mem_q.delete();
    n_mem_wr = 0;
    serve(2'b00, 2'b10, 32'd0);
    check("t3_wr_count", 64'(n_mem_wr), 64'd512);
    check("t3_mem_byte5", {56'd0, mem_byte(24'h100005)}, {56'd0, 8'hFA});

    // 4: simultaneous requests follow fixed priority
    served_log.delete();
    serve(2'b11, 2'b01, 32'd5);
    check("t4_order_len", 64'(served_log.size()), 64'd3);
    check("t4_order", {58'd0, served_log[0], served_log[1], served_log[2]}, {58'd0, 2'b00, 2'b01, 2'b10});

    // 5: out-of-range LBA reads zeros, writes nothing; a valid request clears the flag
    serve(2'b01, 2'b00, MAX_LBA + 32'd1);
    check("t5_err_set", {63'd0, lba_err}, 64'd1);
    n_mem_wr = 0;
    serve(2'b00, 2'b01, MAX_LBA + 32'd1);
    check("t5_no_writes", 64'(n_mem_wr), 64'd0);
    serve(2'b01, 2'b00, 32'd7);
    check("t5_err_clear", {63'd0, lba_err}, 64'd0);

    // 6: random memory wait states must not change data, addresses or strobe count
    mem_delay_max = 7;
    serve(2'b10, 2'b00, 32'd2);
    serve(2'b00, 2'b01, 32'd9);
    serve(2'b01, 2'b00, 32'd9);
    check("t6_readback", {56'd0, mem_byte(24'h001203)}, {56'd0, 8'hFC});
    mem_delay_max = 0;

    repeat (5) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
